// File: rtl/riscv_core_trap_ctrl.sv
// Trap/return controller: accept in IDLE, CSR/priv update and one-cycle redirect two cycles later; ready low while busy.
// Optional supervisor mode (medeleg, S trap CSRs, sret) is enabled with `define RISCV_CORE_SMODE_EN.
module riscv_core_trap_ctrl #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_trap_valid,
    output logic            o_trap_ready,
    input  logic            i_trap_ecall,
    input  logic            i_trap_ebreak,
    input  logic            i_trap_mret,
    input  logic            i_trap_sret,
    input  logic            i_trap_illegal,
    input  logic [XLEN-1:0] i_trap_pc,
    input  logic [31:0]     i_trap_instr,
    input  logic            i_trap_csr_we,
    input  logic [11:0]     i_trap_csr_addr,
    input  logic [XLEN-1:0] i_trap_csr_wdata,
    output logic [XLEN-1:0] o_trap_csr_rdata,
    output logic            o_trap_redirect_valid,
    output logic [XLEN-1:0] o_trap_redirect_pc,
    output logic [1:0]      o_trap_priv
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEDELEG = 12'h302;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_STVEC   = 12'h105;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;
    localparam logic [11:0] CSR_STVAL   = 12'h143;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam logic [XLEN-1:0] MEDELEG_WMASK = ~(XLEN'(1) << 11);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_UPDATE   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic            ev_ecall, ev_ebreak, ev_mret, ev_sret, ev_illegal;
    logic [XLEN-1:0] ev_pc;
    logic [31:0]     ev_instr;

    logic [1:0]      priv;
    logic            mie, mpie;
    logic [1:0]      mpp;
    logic [XLEN-1:0] mtvec, mepc, mcause, mtval;

    logic            sie, spie, spp;
    logic [XLEN-1:0] medeleg, stvec, sepc, scause, stval;

    logic            accept, csr_wr;
    logic            is_trap, is_mret, is_sret, trap_to_s;
    logic [3:0]      cause_code;
    logic [XLEN-1:0] tval;
    logic [XLEN-1:0] mstatus_v;

    assign accept = i_trap_valid && (state == ST_IDLE);
    // An accepting event takes precedence over a same-cycle software write.
    assign csr_wr = i_trap_csr_we && (state == ST_IDLE) && !i_trap_valid;

    function automatic logic [1:0] legal_mpp(input logic [1:0] v);
`ifdef RISCV_CORE_SMODE_EN
        return (v == 2'b10) ? PRIV_U : v;
`else
        return (v == PRIV_M) ? PRIV_M : PRIV_U;
`endif
    endfunction

    always_comb begin
        is_trap    = 1'b0;
        is_mret    = 1'b0;
        is_sret    = 1'b0;
        cause_code = 4'd0;
        tval       = '0;
        if (ev_illegal) begin
            is_trap    = 1'b1;
            cause_code = 4'd2;
            tval       = XLEN'(ev_instr);
        end else if (ev_ebreak) begin
            is_trap    = 1'b1;
            cause_code = 4'd3;
            tval       = ev_pc;
        end else if (ev_ecall) begin
            is_trap = 1'b1;
            case (priv)
                PRIV_U:  cause_code = 4'd8;
                PRIV_S:  cause_code = 4'd9;
                default: cause_code = 4'd11;
            endcase
        end else if (ev_mret) begin
            if (priv == PRIV_M) begin
                is_mret = 1'b1;
            end else begin
                is_trap    = 1'b1;
                cause_code = 4'd2;
                tval       = XLEN'(ev_instr);
            end
        end else if (ev_sret) begin
`ifdef RISCV_CORE_SMODE_EN
            if (priv != PRIV_U) begin
                is_sret = 1'b1;
            end else begin
                is_trap    = 1'b1;
                cause_code = 4'd2;
                tval       = XLEN'(ev_instr);
            end
`else
            is_trap    = 1'b1;
            cause_code = 4'd2;
            tval       = XLEN'(ev_instr);
`endif
        end
    end

`ifdef RISCV_CORE_SMODE_EN
    assign trap_to_s = is_trap && (priv != PRIV_M) && medeleg[cause_code];
`else
    assign trap_to_s = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (i_trap_valid) state_nxt = ST_UPDATE;
            ST_UPDATE:   state_nxt = (is_trap || is_mret || is_sret) ? ST_REDIRECT : ST_IDLE;
            ST_REDIRECT: state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            ev_ecall    <= 1'b0;
            ev_ebreak   <= 1'b0;
            ev_mret     <= 1'b0;
            ev_sret     <= 1'b0;
            ev_illegal  <= 1'b0;
            ev_pc       <= '0;
            ev_instr    <= '0;
            priv        <= PRIV_M;
            mie         <= 1'b0;
            mpie        <= 1'b0;
            mpp         <= PRIV_U;
            mtvec       <= MTVEC_RST;
            mepc        <= '0;
            mcause      <= '0;
            mtval       <= '0;
            o_trap_redirect_pc <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ev_ecall   <= i_trap_ecall;
                ev_ebreak  <= i_trap_ebreak;
                ev_mret    <= i_trap_mret;
                ev_sret    <= i_trap_sret;
                ev_illegal <= i_trap_illegal;
                ev_pc      <= i_trap_pc;
                ev_instr   <= i_trap_instr;
            end
            if (csr_wr) begin
                case (i_trap_csr_addr)
                    CSR_MSTATUS: begin
                        mie  <= i_trap_csr_wdata[3];
                        mpie <= i_trap_csr_wdata[7];
                        mpp  <= legal_mpp(i_trap_csr_wdata[12:11]);
                    end
                    CSR_MTVEC:  mtvec  <= {i_trap_csr_wdata[XLEN-1:2], 2'b00};
                    CSR_MEPC:   mepc   <= {i_trap_csr_wdata[XLEN-1:1], 1'b0};
                    CSR_MCAUSE: mcause <= i_trap_csr_wdata;
                    CSR_MTVAL:  mtval  <= i_trap_csr_wdata;
                    default: ;
                endcase
            end
            if (state == ST_UPDATE) begin
                if (is_trap && !trap_to_s) begin
                    mepc   <= ev_pc;
                    mcause <= XLEN'(cause_code);
                    mtval  <= tval;
                    mpie   <= mie;
                    mie    <= 1'b0;
                    mpp    <= priv;
                    priv   <= PRIV_M;
                    o_trap_redirect_pc <= mtvec;
                end else if (is_trap) begin
                    priv <= PRIV_S;
                    o_trap_redirect_pc <= stvec;
                end else if (is_mret) begin
                    priv <= mpp;
                    mie  <= mpie;
                    mpie <= 1'b1;
                    mpp  <= PRIV_U;
                    o_trap_redirect_pc <= mepc;
                end else if (is_sret) begin
                    priv <= {1'b0, spp};
                    o_trap_redirect_pc <= sepc;
                end
            end
        end
    end

`ifdef RISCV_CORE_SMODE_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sie     <= 1'b0;
            spie    <= 1'b0;
            spp     <= 1'b0;
            medeleg <= '0;
            stvec   <= '0;
            sepc    <= '0;
            scause  <= '0;
            stval   <= '0;
        end else begin
            if (csr_wr) begin
                case (i_trap_csr_addr)
                    CSR_MSTATUS: begin
                        sie  <= i_trap_csr_wdata[1];
                        spie <= i_trap_csr_wdata[5];
                        spp  <= i_trap_csr_wdata[8];
                    end
                    CSR_MEDELEG: medeleg <= i_trap_csr_wdata & MEDELEG_WMASK;
                    CSR_STVEC:   stvec   <= {i_trap_csr_wdata[XLEN-1:2], 2'b00};
                    CSR_SEPC:    sepc    <= {i_trap_csr_wdata[XLEN-1:1], 1'b0};
                    CSR_SCAUSE:  scause  <= i_trap_csr_wdata;
                    CSR_STVAL:   stval   <= i_trap_csr_wdata;
                    default: ;
                endcase
            end
            if (state == ST_UPDATE) begin
                if (trap_to_s) begin
                    sepc   <= ev_pc;
                    scause <= XLEN'(cause_code);
                    stval  <= tval;
                    spie   <= sie;
                    sie    <= 1'b0;
                    spp    <= priv[0];
                end else if (is_sret) begin
                    sie  <= spie;
                    spie <= 1'b1;
                    spp  <= 1'b0;
                end
            end
        end
    end
`else
    assign sie     = 1'b0;
    assign spie    = 1'b0;
    assign spp     = 1'b0;
    assign medeleg = '0;
    assign stvec   = '0;
    assign sepc    = '0;
    assign scause  = '0;
    assign stval   = '0;
`endif

    always_comb begin
        mstatus_v        = '0;
        mstatus_v[1]     = sie;
        mstatus_v[3]     = mie;
        mstatus_v[5]     = spie;
        mstatus_v[7]     = mpie;
        mstatus_v[8]     = spp;
        mstatus_v[12:11] = mpp;
    end

    always_comb begin
        case (i_trap_csr_addr)
            CSR_MSTATUS: o_trap_csr_rdata = mstatus_v;
            CSR_MEDELEG: o_trap_csr_rdata = medeleg;
            CSR_MTVEC:   o_trap_csr_rdata = mtvec;
            CSR_MEPC:    o_trap_csr_rdata = mepc;
            CSR_MCAUSE:  o_trap_csr_rdata = mcause;
            CSR_MTVAL:   o_trap_csr_rdata = mtval;
            CSR_STVEC:   o_trap_csr_rdata = stvec;
            CSR_SEPC:    o_trap_csr_rdata = sepc;
            CSR_SCAUSE:  o_trap_csr_rdata = scause;
            CSR_STVAL:   o_trap_csr_rdata = stval;
            default:     o_trap_csr_rdata = '0;
        endcase
    end

    assign o_trap_ready          = (state == ST_IDLE);
    assign o_trap_redirect_valid = (state == ST_REDIRECT);
    assign o_trap_priv           = priv;

endmodule
